// File: rtl/ddr2_wr_burst_if.sv
// rtl/ddr2_wr_burst_if.sv - beat stream input and AXI4 write channels of ddr2_wr_burst
//
// Purpose: bundles the packer-side beat stream (valid/ready) and the AXI4
// AW/W/B channels that ddr2_wr_burst drives towards external DDR.
// Modports:
//   master : the write-burst engine (consumes the beat stream, masters AXI)
//   slave  : its environment (packer feeding beats, DDR AXI slave)
// Signals:
//   in_data/in_valid/in_ready          beat stream from the packer
//   m_awaddr/awlen/awsize/awburst/awvalid/awready   AXI AW channel
//   m_wdata/wstrb/wlast/wvalid/wready               AXI W channel
//   m_bresp/bvalid/bready                           AXI B channel
interface ddr2_wr_burst_if #(
  parameter int DDR_W      = 512,
  parameter int AXI_ADDR_W = 32
);
  localparam int BPB = DDR_W / 8;

  logic [DDR_W-1:0]      in_data;
  logic                  in_valid;
  logic                  in_ready;

  logic [AXI_ADDR_W-1:0] m_awaddr;
  logic [7:0]            m_awlen;
  logic [2:0]            m_awsize;
  logic [1:0]            m_awburst;
  logic                  m_awvalid;
  logic                  m_awready;

  logic [DDR_W-1:0]      m_wdata;
  logic [BPB-1:0]        m_wstrb;
  logic                  m_wlast;
  logic                  m_wvalid;
  logic                  m_wready;

  logic [1:0]            m_bresp;
  logic                  m_bvalid;
  logic                  m_bready;

  modport master (
    input  in_data, in_valid, m_awready, m_wready, m_bresp, m_bvalid,
    output in_ready,
    output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_bready
  );

  modport slave (
    output in_data, in_valid, m_awready, m_wready, m_bresp, m_bvalid,
    input  in_ready,
    input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_bready
  );
endinterface

// File: rtl/ddr2_wr_burst.sv
// rtl/ddr2_wr_burst.sv - buffers packer beats and writes them to DDR as AXI4 INCR bursts
//
// Purpose: each transfer (started by a one-cycle start pulse) writes
// conf_trans_num beats from the packer stream to DDR starting at
// conf_base_addr, split into bursts of at most MAX_BURST beats with at most
// MAX_OUTS bursts awaiting their B response. done pulses once every beat is
// written and every B response has returned.
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   start           one-cycle pulse, latches conf_*; ignored while busy
//   done            one-cycle pulse, transfer complete
//   busy            high from start until the done pulse
//   err             sticky, some bresp != OKAY; cleared by start
//   conf_base_addr  byte address, aligned to MAX_BURST*BPB
//   conf_trans_num  beats to write (0 allowed)
//   bus             beat stream + AXI AW/W/B channels (master modport)
module ddr2_wr_burst #(
  parameter int DDR_W      = 512,
  parameter int AXI_ADDR_W = 32,
  parameter int FIFO_DEPTH = 64,
  parameter int MAX_BURST  = 16,
  parameter int MAX_OUTS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  output logic                  busy,
  output logic                  err,
  input  logic [AXI_ADDR_W-1:0] conf_base_addr,
  input  logic [15:0]           conf_trans_num,
  ddr2_wr_burst_if.master       bus
);

  localparam int BPB    = DDR_W / 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LEN_W  = $clog2(MAX_BURST) + 1;
  localparam int OUTS_W = $clog2(MAX_OUTS + 1);
  localparam int SIZE   = $clog2(BPB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ADDR,
    S_DATA,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]           rem_q, rem_d;
  logic [15:0]           num_q, num_d;
  logic [15:0]           in_cnt_q, in_cnt_d;
  logic [LEN_W-1:0]      awlen_q, awlen_d;
  logic [LEN_W-1:0]      beat_q, beat_d;
  logic [OUTS_W-1:0]     outs_q, outs_d;
  logic                  err_q, err_d;

  logic [DDR_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;

  logic                  fifo_full, fifo_empty;
  logic                  in_fire, push, pop;
  logic                  aw_fire, w_fire, b_fire;
  logic                  awvalid, wvalid, wlast;
  logic [LEN_W-1:0]      burst_len;

  // ---------------------------------------------------------------- status
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Beats beyond conf_trans_num are accepted but not stored, so an
  // overrunning packer is drained instead of stalling.
  assign in_fire    = bus.in_valid && bus.in_ready;
  assign push       = in_fire && (in_cnt_q < num_q);

  assign aw_fire    = awvalid && bus.m_awready;
  assign w_fire     = wvalid && bus.m_wready;
  assign b_fire     = bus.m_bvalid && bus.m_bready;
  assign pop        = w_fire;

  assign burst_len  = (rem_q > 16'(MAX_BURST)) ? LEN_W'(MAX_BURST) : LEN_W'(rem_q);

  // AW is only raised once a slot for another outstanding burst exists; the
  // outstanding count cannot grow while waiting, so awvalid never retracts.
  assign awvalid    = (state_q == S_ADDR) && (outs_q != OUTS_W'(MAX_OUTS));
  // The whole burst is already buffered when DATA is entered, so wvalid is
  // effectively steady; it still follows the FIFO to be safe.
  assign wvalid     = (state_q == S_DATA) && !fifo_empty;
  assign wlast      = (state_q == S_DATA) && (beat_q == awlen_q);

  // ---------------------------------------------------------------- outputs
  assign bus.in_ready  = busy && !fifo_full;
  assign bus.m_awaddr  = addr_q;
  assign bus.m_awlen   = 8'(awlen_q);
  assign bus.m_awsize  = 3'(SIZE);
  assign bus.m_awburst = 2'b01;
  assign bus.m_awvalid = awvalid;
  assign bus.m_wdata   = mem_q[rd_ptr_q];
  assign bus.m_wstrb   = '1;
  assign bus.m_wlast   = wlast;
  assign bus.m_wvalid  = wvalid;
  assign bus.m_bready  = busy;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      num_q    <= '0;
      in_cnt_q <= '0;
      awlen_q  <= '0;
      beat_q   <= '0;
      outs_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      num_q    <= num_d;
      in_cnt_q <= in_cnt_d;
      awlen_q  <= awlen_d;
      beat_q   <= beat_d;
      outs_q   <= outs_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    num_d    = num_q;
    in_cnt_d = in_cnt_q;
    awlen_d  = awlen_q;
    beat_d   = beat_q;
    err_d    = err_q;

    if (push) begin
      in_cnt_d = in_cnt_q + 16'd1;
    end
    if (b_fire && (bus.m_bresp != 2'b00)) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d    = conf_trans_num;
          rem_d    = conf_trans_num;
          addr_d   = conf_base_addr;
          in_cnt_d = '0;
          err_d    = 1'b0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rem_q == '0) begin
          state_d = S_DRAIN;
        end else if (count_q >= CNT_W'(burst_len)) begin
          awlen_d = burst_len - LEN_W'(1);
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (aw_fire) begin
          addr_d  = addr_q + (AXI_ADDR_W'(awlen_q) + AXI_ADDR_W'(1)) * AXI_ADDR_W'(BPB);
          rem_d   = rem_q - 16'(awlen_q) - 16'd1;
          beat_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_fire) begin
          beat_d = beat_q + LEN_W'(1);
          if (wlast) begin
            state_d = S_WAIT;
          end
        end
      end
      S_DRAIN: begin
        if (outs_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A burst issued and a response retired in the same cycle cancel out.
  always_comb begin
    outs_d = outs_q;
    if (aw_fire && !b_fire) begin
      outs_d = outs_q + OUTS_W'(1);
    end else if (!aw_fire && b_fire) begin
      outs_d = outs_q - OUTS_W'(1);
    end
  end

  // ---------------------------------------------------------------- FIFO
  // in_ready is derived from the registered count, so a pop while full only
  // frees a slot for the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_ddr2_wr_burst.sv
// tb/tb_ddr2_wr_burst.sv - scoreboard bench for ddr2_wr_burst
module tb_ddr2_wr_burst;

  localparam int DDR_W      = 512;
  localparam int AXI_ADDR_W = 32;
  localparam int FIFO_DEPTH = 64;
  localparam int MAX_BURST  = 16;
  localparam int MAX_OUTS   = 4;
  localparam int BPB        = DDR_W / 8;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
  } aw_t;

  typedef struct packed {
    logic [DDR_W-1:0] data;
    logic             last;
  } w_t;

  typedef struct packed {
    logic [31:0] due;
    logic [1:0]  resp;
  } b_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start = 1'b0;
  logic                  done, busy, err;
  logic [AXI_ADDR_W-1:0] conf_base_addr = '0;
  logic [15:0]           conf_trans_num = '0;

  ddr2_wr_burst_if #(.DDR_W(DDR_W), .AXI_ADDR_W(AXI_ADDR_W)) bus ();

  ddr2_wr_burst #(
    .DDR_W(DDR_W), .AXI_ADDR_W(AXI_ADDR_W), .FIFO_DEPTH(FIFO_DEPTH),
    .MAX_BURST(MAX_BURST), .MAX_OUTS(MAX_OUTS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy), .err(err),
    .conf_base_addr(conf_base_addr), .conf_trans_num(conf_trans_num), .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  aw_t exp_aw[$];
  w_t  exp_w[$];
  b_t  b_q[$];

  int in_pct = 100, w_pct = 100, bad_b = -1;
  bit aw_en = 1'b1;
  int xfer_num = 0, in_idx = 0, accepted = 0, b_idx = 0;
  int aw_seen = 0, w_bursts = 0, w_beats = 0, outs_tb = 0, done_cnt = 0;
  int unsigned start_cyc = 0, done_cyc = 0;
  bit exp_err = 1'b0, any_axi = 1'b0;

  function automatic void check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  function automatic void check_vec(input string name, input logic [DDR_W-1:0] act,
                                    input logic [DDR_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // ------------------------------------------------------------ beat source
  bit in_fire_n;
  always @(negedge clk) in_fire_n = rst && bus.in_valid && bus.in_ready;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      bus.in_valid = 1'b0;
    end else begin
      if (in_fire_n) begin
        accepted++;
        if (in_idx < xfer_num) begin
          exp_w.push_back(w_t'{data: bus.in_data,
                               last: ((in_idx + 1) % MAX_BURST == 0) || (in_idx + 1 == xfer_num)});
        end
        in_idx++;
        bus.in_valid = 1'b0;
      end
      if (!bus.in_valid && (int'($urandom_range(99)) < in_pct)) begin
        for (int i = 0; i < DDR_W / 32; i++) bus.in_data[i*32 +: 32] = $urandom;
        bus.in_valid = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------ AXI slave
  initial begin
    bus.m_awready = 1'b0;
    bus.m_wready  = 1'b0;
    bus.m_bvalid  = 1'b0;
    bus.m_bresp   = 2'b00;
  end

  always @(posedge clk) begin
    #1;
    bus.m_wready  = rst && (int'($urandom_range(99)) < w_pct);
    bus.m_awready = rst && aw_en;
  end

  bit b_fire_n;
  always @(negedge clk) b_fire_n = rst && bus.m_bvalid && bus.m_bready;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      bus.m_bvalid = 1'b0;
      bus.m_bresp  = 2'b00;
    end else begin
      if (b_fire_n) begin
        bus.m_bvalid = 1'b0;
        if (b_q.size() > 0) void'(b_q.pop_front());
      end
      if (!bus.m_bvalid && b_q.size() > 0 && cyc >= b_q[0].due) begin
        bus.m_bvalid = 1'b1;
        bus.m_bresp  = b_q[0].resp;
      end
    end
  end

  // ------------------------------------------------------------ monitor
  bit prev_awv, prev_awf, prev_wv, prev_wf;
  aw_t prev_aw;
  logic [DDR_W-1:0] prev_wdata;

  always @(negedge clk) begin
    aw_t e;
    w_t ew;
    if (!rst) begin
      prev_awv = 1'b0;
      prev_wv  = 1'b0;
    end else begin
      if (bus.m_awvalid || bus.m_wvalid) any_axi = 1'b1;
      if (prev_awv && !prev_awf) begin
        check_int("aw_valid_hold", int'(bus.m_awvalid), 1);
        check_vec("aw_payload_hold", DDR_W'({bus.m_awaddr, bus.m_awlen}), DDR_W'(prev_aw));
      end
      if (prev_wv && !prev_wf) begin
        check_int("w_valid_hold", int'(bus.m_wvalid), 1);
        check_vec("w_data_hold", bus.m_wdata, prev_wdata);
      end
      if (bus.m_awvalid && bus.m_awready) begin
        if (exp_aw.size() == 0) begin
          check_int("aw_unexpected", 1, 0);
        end else begin
          e = exp_aw.pop_front();
          check_vec("aw_addr", DDR_W'(bus.m_awaddr), DDR_W'(e.addr));
          check_int("aw_len", int'(bus.m_awlen), int'(e.len));
        end
        aw_seen++;
        outs_tb++;
        check_int("outs_limit", int'(outs_tb <= MAX_OUTS), 1);
      end
      if (bus.m_wvalid && bus.m_wready) begin
        check_int("w_after_aw", int'(w_bursts < aw_seen), 1);
        if (exp_w.size() == 0) begin
          check_int("w_unexpected", 1, 0);
        end else begin
          ew = exp_w.pop_front();
          check_vec("w_data", bus.m_wdata, ew.data);
          check_int("w_last", int'(bus.m_wlast), int'(ew.last));
        end
        w_beats++;
        if (bus.m_wlast) begin
          w_bursts++;
          b_q.push_back(b_t'{due: cyc + 2, resp: (b_idx == bad_b) ? 2'b10 : 2'b00});
          b_idx++;
        end
      end
      if (bus.m_bvalid && bus.m_bready) outs_tb--;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check_int("done_aw_left", exp_aw.size(), 0);
        check_int("done_w_left", exp_w.size(), 0);
        check_int("done_b_left", b_q.size(), 0);
        check_int("done_beats", w_beats, xfer_num);
        check_int("done_err", int'(err), int'(exp_err));
      end
      prev_awv   = bus.m_awvalid;
      prev_awf   = bus.m_awvalid && bus.m_awready;
      prev_aw    = aw_t'{addr: bus.m_awaddr, len: bus.m_awlen};
      prev_wv    = bus.m_wvalid;
      prev_wf    = bus.m_wvalid && bus.m_wready;
      prev_wdata = bus.m_wdata;
    end
  end

  // ------------------------------------------------------------ sequencing
  task automatic start_xfer(input logic [31:0] base, input int num);
    int l;
    for (int k = 0; k * MAX_BURST < num; k++) begin
      l = (num - k * MAX_BURST > MAX_BURST) ? MAX_BURST : num - k * MAX_BURST;
      exp_aw.push_back(aw_t'{addr: base + 32'(k * MAX_BURST * BPB), len: 8'(l - 1)});
    end
    xfer_num = num; in_idx = 0; accepted = 0; b_idx = 0;
    aw_seen = 0; w_bursts = 0; w_beats = 0; outs_tb = 0; any_axi = 1'b0;
    exp_err = (bad_b >= 0) && (bad_b < (num + MAX_BURST - 1) / MAX_BURST);
    conf_base_addr = base;
    conf_trans_num = 16'(num);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n0, t;
    n0 = done_cnt;
    t = 0;
    while (done_cnt == n0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    check_int({name, "_done_seen"}, int'(done_cnt != n0), 1);
    repeat (3) @(posedge clk);
    #1;
    check_int({name, "_single_done"}, done_cnt, n0 + 1);
    check_int({name, "_idle"}, int'(busy), 0);
  endtask

  function automatic logic [47:0] ctrl_outs();
    return {bus.in_ready, bus.m_awvalid, bus.m_wvalid, bus.m_wlast, bus.m_bready,
            done, busy, err, bus.m_awaddr, bus.m_awlen};
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [31:0] base;
    @(negedge clk);
    check_vec("reset_outputs", DDR_W'(ctrl_outs()), '0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: straight-through, three bursts
    start_xfer(32'h1000, 40);
    wait_done("t1");
    check_int("t1_bursts", aw_seen, 3);
    check_int("t1_wlast_count", w_bursts, 3);

    // 2: random ready / valid, a few transfers
    in_pct = 30; w_pct = 50;
    for (int r = 0; r < 4; r++) begin
      base = (r == 0) ? 32'h1000 : ($urandom & 32'h0FFF_FC00);
      start_xfer(base, (r == 0) ? 40 : int'($urandom_range(1, 70)));
      wait_done("t2");
    end

    // 3: AW blocked, FIFO fills and back-pressures
    in_pct = 100; w_pct = 100; aw_en = 1'b0;
    start_xfer(32'h0, 100);
    repeat (200) @(posedge clk);
    @(negedge clk);
    check_int("t3_accepted_when_full", accepted, FIFO_DEPTH);
    check_int("t3_in_ready_low", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    aw_en = 1'b1;
    wait_done("t3");
    check_int("t3_bursts", aw_seen, 7);

    // 4: zero-length transfer
    start_xfer(32'h0, 0);
    wait_done("t4");
    check_int("t4_done_latency", int'(done_cyc - start_cyc), 3);
    check_int("t4_no_axi", int'(any_axi), 0);

    // 5: error response on second burst, sticky until next start
    bad_b = 1;
    start_xfer(32'h2000, 40);
    wait_done("t5");
    bad_b = -1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_int("t5_err_sticky", int'(err), 1);
    @(posedge clk); #1;
    start_xfer(32'h3000, 8);
    @(negedge clk);
    check_int("t5_err_cleared", int'(err), 0);
    wait_done("t5b");

    // 6: reset in the middle of burst 2, then a clean transfer
    start_xfer(32'h4000, 40);
    t = 0;
    while (w_beats < 20 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check_int("t6_reached_burst2", int'(w_beats >= 20), 1);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_vec("t6_reset_outputs", DDR_W'(ctrl_outs()), '0);
    exp_aw.delete();
    exp_w.delete();
    b_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_vec("t6_reset_outputs_held", DDR_W'(ctrl_outs()), '0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    start_xfer(32'h5000, 16);
    wait_done("t6");
    check_int("t6_single_burst", aw_seen, 1);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
